// File: rtl/hex_ascii_stream.sv
// Streams a registered hex value as ASCII characters over a valid/ready port,
// with an optional "0x" prefix, lowercase letters and leading-zero suppression.
module hex_ascii_stream #(
  parameter int NIBBLES        = 4,
  parameter int LOWER          = 0,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int PREFIX         = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   value,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic [7:0]             char_data,
  output logic                   char_last,
  output logic                   busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, PFX0, PFX1, DIGIT} state_t;

  state_t               state, state_nx;
  logic [4*NIBBLES-1:0] val_q;
  logic [4*NIBBLES-1:0] shifted;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        start_idx;
  logic [3:0]           nib;
  logic                 accept;
  logic                 beat;

  // Starting digit: highest nonzero nibble when suppressing, so a zero value
  // still yields a single '0'.
  always_comb begin
    start_idx = TOP_IDX;
    if (SUPPRESS_ZEROS != 0) begin
      start_idx = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (value[4*i +: 4] != 4'h0) start_idx = i[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      val_q <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        val_q <= value;
        idx   <= start_idx;
      end else if (beat && state == DIGIT && idx != '0) begin
        idx <= idx - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    char_valid  = (state != IDLE);
    char_data   = '0;
    char_last   = 1'b0;
    accept      = start_valid && (state == IDLE);
    beat        = (state != IDLE) && char_ready;
    shifted     = val_q >> {idx, 2'b00};
    nib         = shifted[3:0];

    case (state)
      IDLE: begin
        if (accept) state_nx = (PREFIX != 0) ? PFX0 : DIGIT;
      end
      PFX0: begin
        char_data = 8'h30;
        if (beat) state_nx = PFX1;
      end
      PFX1: begin
        char_data = 8'h78;
        if (beat) state_nx = DIGIT;
      end
      DIGIT: begin
        if (nib < 4'd10) char_data = 8'h30 + {4'h0, nib};
        else             char_data = ((LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, nib};
        char_last = (idx == '0);
        if (beat && char_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_ascii_stream.sv
// Self-checking bench: five parameter configurations, directed and random
// conversions compared against a string-formatting reference model.
module tb_hex_ascii_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-instance configuration: defaults, lower+suppress, prefix, 1 nibble, 16 nibbles
  int cfg_n   [5] = '{4, 4, 4, 1, 16};
  int cfg_low [5] = '{0, 1, 0, 0, 0};
  int cfg_sz  [5] = '{0, 1, 0, 0, 0};
  int cfg_pfx [5] = '{0, 0, 1, 0, 0};

  logic        sv [5];
  logic        sr [5];
  logic [63:0] val[5];
  logic        cv [5];
  logic        cr [5];
  logic [7:0]  cd [5];
  logic        cl [5];
  logic        bz [5];

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  hex_ascii_stream #(.NIBBLES(4), .LOWER(0), .SUPPRESS_ZEROS(0), .PREFIX(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]), .value(val[0][15:0]),
    .char_valid(cv[0]), .char_ready(cr[0]), .char_data(cd[0]), .char_last(cl[0]), .busy(bz[0]));
  hex_ascii_stream #(.NIBBLES(4), .LOWER(1), .SUPPRESS_ZEROS(1), .PREFIX(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]), .value(val[1][15:0]),
    .char_valid(cv[1]), .char_ready(cr[1]), .char_data(cd[1]), .char_last(cl[1]), .busy(bz[1]));
  hex_ascii_stream #(.NIBBLES(4), .LOWER(0), .SUPPRESS_ZEROS(0), .PREFIX(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]), .value(val[2][15:0]),
    .char_valid(cv[2]), .char_ready(cr[2]), .char_data(cd[2]), .char_last(cl[2]), .busy(bz[2]));
  hex_ascii_stream #(.NIBBLES(1), .LOWER(0), .SUPPRESS_ZEROS(0), .PREFIX(0)) u3 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[3]), .start_ready(sr[3]), .value(val[3][3:0]),
    .char_valid(cv[3]), .char_ready(cr[3]), .char_data(cd[3]), .char_last(cl[3]), .busy(bz[3]));
  hex_ascii_stream #(.NIBBLES(16), .LOWER(0), .SUPPRESS_ZEROS(0), .PREFIX(0)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[4]), .start_ready(sr[4]), .value(val[4]),
    .char_valid(cv[4]), .char_ready(cr[4]), .char_data(cd[4]), .char_last(cl[4]), .busy(bz[4]));

  // Reference: print the value digit by digit, most significant first.
  function automatic void build_exp(input int k, input logic [63:0] v);
    logic [63:0] nib;
    bit started;
    expq.delete();
    if (cfg_pfx[k] != 0) begin
      expq.push_back("0");
      expq.push_back("x");
    end
    started = 1'b0;
    for (int d = cfg_n[k] - 1; d >= 0; d--) begin
      nib = (v >> (4 * d)) & 64'hF;
      if (cfg_sz[k] != 0 && !started && nib == 0 && d != 0) continue;
      started = 1'b1;
      if (nib < 10) expq.push_back(8'("0" + nib));
      else          expq.push_back(8'(((cfg_low[k] != 0) ? "a" : "A") + nib - 10));
    end
  endfunction

  function automatic logic [63:0] width_mask(input int n);
    return (n >= 16) ? '1 : ((64'h1 << (4 * n)) - 64'h1);
  endfunction

  // One conversion on instance k; stall_pct randomizes char_ready, and a fixed
  // stall of fix_len cycles (with a stray start pulse) can be placed on beat fix_beat.
  task automatic run_conv(input int k, input logic [63:0] v, input int stall_pct,
                          input int fix_beat, input int fix_len);
    int wait_cyc;
    int beat_i;
    int cyc;
    int stalls;
    build_exp(k, v);
    wait_cyc = 0;
    while (!sr[k] && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    checks++;
    if (sr[k] !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_wait k=%0d got %b want 1", k, sr[k]);
    end
    sv[k]  = 1'b1;
    val[k] = v;
    @(posedge clk); #1;
    sv[k]  = 1'b0;
    val[k] = {$urandom, $urandom};
    beat_i = 0;
    cyc    = 0;
    stalls = 0;
    while (beat_i < expq.size() && cyc < 2000) begin
      checks++;
      if (cv[k] !== 1'b1) begin
        errors++;
        $display("FAIL char_valid k=%0d beat=%0d got %b want 1", k, beat_i, cv[k]);
      end
      checks++;
      if (cd[k] !== expq[beat_i]) begin
        errors++;
        $display("FAIL char_data k=%0d beat=%0d got %h want %h", k, beat_i, cd[k], expq[beat_i]);
      end
      checks++;
      if (cl[k] !== (beat_i == expq.size() - 1)) begin
        errors++;
        $display("FAIL char_last k=%0d beat=%0d got %b want %b", k, beat_i, cl[k],
                 (beat_i == expq.size() - 1));
      end
      checks++;
      if (bz[k] !== 1'b1 || sr[k] !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready k=%0d beat=%0d got busy=%b ready=%b want 1/0", k, beat_i, bz[k], sr[k]);
      end
      if (beat_i == fix_beat && stalls < fix_len) begin
        cr[k] = 1'b0;
        if (stalls == 0) begin
          sv[k]  = 1'b1;
          val[k] = ~v;
        end
        stalls++;
      end else begin
        cr[k] = ($urandom_range(0, 99) >= stall_pct);
        if (!cr[k] && $urandom_range(0, 1) == 1) begin
          sv[k]  = 1'b1;
          val[k] = {$urandom, $urandom};
        end
      end
      @(posedge clk); #1;
      sv[k] = 1'b0;
      if (cr[k]) beat_i++;
      cyc++;
    end
    cr[k] = 1'b0;
    checks++;
    if (beat_i != expq.size()) begin
      errors++;
      $display("FAIL beat_count k=%0d got %0d want %0d", k, beat_i, expq.size());
    end
    checks++;
    if (cv[k] !== 1'b0 || bz[k] !== 1'b0 || sr[k] !== 1'b1) begin
      errors++;
      $display("FAIL end_state k=%0d got valid=%b busy=%b ready=%b want 0/0/1", k, cv[k], bz[k], sr[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sv[k] = 1'b0; cr[k] = 1'b0; val[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sr[k] !== 1'b1 || cv[k] !== 1'b0 || cl[k] !== 1'b0 || cd[k] !== 8'h00 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state k=%0d got ready=%b valid=%b last=%b data=%h busy=%b want 1/0/0/00/0",
                 k, sr[k], cv[k], cl[k], cd[k], bz[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_conv(0, 64'h0A3F, 0, -1, 0);
    run_conv(1, 64'h00B2, 0, -1, 0);
    run_conv(1, 64'h0000, 0, -1, 0);
    run_conv(2, 64'h1234, 0, -1, 0);
    run_conv(3, 64'h9, 0, -1, 0);
    run_conv(4, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_conv(0, 64'hFFFF, 0, 1, 3);
    run_conv(2, 64'hA0C1, 0, 0, 2);
  endtask

  task automatic test_reset_mid();
    sv[2]  = 1'b1;
    val[2] = 64'h1234;
    cr[2]  = 1'b1;
    @(posedge clk); #1;
    sv[2] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (cv[2] !== 1'b1 || cd[2] !== 8'h31) begin
      errors++;
      $display("FAIL mid_beat3 got valid=%b data=%h want 1/31", cv[2], cd[2]);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cr[2] = 1'b0;
    checks++;
    if (cv[2] !== 1'b0 || bz[2] !== 1'b0 || sr[2] !== 1'b1 || cd[2] !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got valid=%b busy=%b ready=%b data=%h want 0/0/1/00",
               cv[2], bz[2], sr[2], cd[2]);
    end
    run_conv(2, 64'h0001, 0, -1, 0);
  endtask

  task automatic test_random();
    logic [63:0] v;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 12; t++) begin
        v = {$urandom, $urandom} & width_mask(cfg_n[k]);
        v = v >> (4 * $urandom_range(0, cfg_n[k]));
        run_conv(k, v, 30, -1, 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
